// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer fed from the transmit FIFO.
// Pops one byte per frame, waits for the FIFO read pipeline, then sends
// start bit, 7 or 8 data bits LSB first, optional parity bit and one stop bit.
// Bit timing is derived from a 16x oversample enable.
//
// Ports:
//   clock       system clock, shared with the FIFO
//   reset_n     asynchronous active-low reset
//   baud_en     single-cycle 16x baud tick
//   bit8        1 = 8 data bits, 0 = 7 data bits
//   parity_en   1 = append parity bit
//   odd_n_even  1 = odd parity, 0 = even parity
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO output data
//   fifo_read_n active-low single-cycle pop strobe
//   tx          serial output, idles high
//   tx_busy     high whenever a frame is in progress (pop through stop bit)
//   tx_done     single-cycle pulse on the cycle the stop bit completes
module uart_tx_fifo_drain #(
   parameter int unsigned FETCH_LAT  = 3,  // must be >= 2
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       baud_en,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_n,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned FetchW = (FETCH_LAT > 2) ? $clog2(FETCH_LAT - 1) : 1;
   localparam logic [FetchW-1:0] LastFetch = FetchW'(FETCH_LAT - 2);
   localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StFetch,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        tick_q, tick_d;
   logic [FetchW-1:0] fetch_q, fetch_d;
   logic [3:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              bit8_q, bit8_d;
   logic              par_en_q, par_en_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;

   logic              bit_end;

   // A serial bit ends on the baud tick that wraps the oversample counter.
   assign bit_end = baud_en && (tick_q == LastTick);

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      fetch_d  = fetch_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      bit8_d   = bit8_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      tx_done  = 1'b0;

      // The oversample counter only runs while a bit is on the line.
      if (baud_en && (state_q inside {StStart, StData, StParity, StStop})) begin
         tick_d = tick_q + 4'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d = StPop;
            end
         end
         StPop: begin
            fetch_d = '0;
            state_d = StFetch;
         end
         StFetch: begin
            if (fetch_q == LastFetch) begin
               // Byte and frame format are frozen here for the whole frame.
               shift_d  = fifo_data;
               bit8_d   = bit8;
               par_en_d = parity_en;
               par_d    = (bit8 ? ^fifo_data : ^fifo_data[6:0]) ^ odd_n_even;
               tick_d   = '0;
               bit_d    = '0;
               state_d  = StStart;
            end else begin
               fetch_d = fetch_q + 1'b1;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_d == (bit8_q ? 4'd8 : 4'd7)) begin
                  state_d = par_en_q ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               tx_done = 1'b1;
               // Back-to-back frames go straight to the next pop, no idle bit.
               state_d = fifo_empty ? StIdle : StPop;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // tx is decoded from the next state so the registered line changes
      // together with the state register.
      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         tick_q   <= '0;
         fetch_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         bit8_q   <= 1'b0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         fetch_q  <= fetch_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         bit8_q   <= bit8_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
      end
   end

   assign fifo_read_n = (state_q != StPop);
   assign tx_busy     = (state_q != StIdle);
   assign tx          = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: a behavioural FIFO with a 3-cycle
// read pipeline feeds the DUT; frames are sampled mid-bit and compared with
// hand-built expected frames.
module tb_uart_tx_fifo_drain;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_en = 1'b0;
   logic       bit8 = 1'b1;
   logic       parity_en = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_read_n;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   int unsigned cyc = 0;
   int unsigned baud_div = 1;

   logic [7:0]  fifo_q[$];
   logic [7:0]  held = 8'h00;
   int unsigned lat_cnt = 0;
   int unsigned bad_pop = 0;

   int unsigned pop_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned fall_cnt = 0;
   int unsigned last_pop = 0;
   int unsigned last_done = 0;
   int unsigned last_fall = 0;
   int unsigned last_rise = 0;
   logic        tx_prev = 1'b1;

   // Scratch for the directed sequence.
   logic [15:0] frame_a, frame_b;
   int unsigned t0_a, t0_b, d1, pops0, dones0, falls0;

   uart_tx_fifo_drain dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .baud_en    (baud_en),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read_n(fifo_read_n),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #1;
      baud_en = ((cyc % baud_div) == 0);
   end

   // FIFO model: byte is valid only in the third cycle counting the pop cycle.
   always @(posedge clock) begin
      #1;
      fifo_data = ~held;
      if (lat_cnt != 0) begin
         lat_cnt = lat_cnt - 1;
         if (lat_cnt == 0) fifo_data = held;
      end
      if (!fifo_read_n) begin
         if (fifo_q.size() == 0) begin
            bad_pop = bad_pop + 1;
         end else begin
            held    = fifo_q.pop_front();
            lat_cnt = 2;
         end
      end
      fifo_empty = (fifo_q.size() == 0);
   end

   always @(negedge clock) begin
      if (tx_done) begin
         done_cnt  = done_cnt + 1;
         last_done = cyc;
      end
      if (!fifo_read_n) begin
         pop_cnt  = pop_cnt + 1;
         last_pop = cyc;
      end
      if (tx_prev && !tx) begin
         fall_cnt  = fall_cnt + 1;
         last_fall = cyc;
      end
      if (!tx_prev && tx) last_rise = cyc;
      tx_prev = tx;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait for the next start bit, then sample nbits bits mid-bit.
   task automatic capture(input string tag, input int unsigned nbits,
                          output logic [15:0] frame, output int unsigned t0);
      int unsigned f0 = fall_cnt;
      int unsigned budget = 3000;
      int unsigned p = 16 * baud_div;
      frame = '0;
      t0    = 0;
      while (fall_cnt == f0 && budget > 0) begin
         @(negedge clock);
         budget = budget - 1;
      end
      check_eq({tag, "_start_seen"}, 32'(fall_cnt != f0), 32'd1);
      if (fall_cnt == f0) return;
      t0 = last_fall;
      for (int unsigned i = 0; i < nbits; i++) begin
         while (cyc < t0 + p * i + p / 2) @(negedge clock);
         frame[i] = tx;
      end
   endtask

   task automatic wait_idle(input string tag);
      int unsigned budget = 3000;
      @(negedge clock);
      while ((tx_busy || !fifo_empty) && budget > 0) begin
         @(negedge clock);
         budget = budget - 1;
      end
      check_eq({tag, "_idle"}, 32'(tx_busy), 32'd0);
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_read_n", 32'(fifo_read_n), 32'd1);
      check_eq("rst_busy", 32'(tx_busy), 32'd0);
      check_eq("rst_done", 32'(tx_done), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Single byte 0xA5, 8N1
      pops0 = pop_cnt;
      push(8'hA5);
      capture("a5", 10, frame_a, t0_a);
      check_eq("a5_frame", 32'(frame_a), 32'({1'b1, 8'hA5, 1'b0}));
      check_eq("a5_fetch_lat", t0_a - last_pop, 32'd3);
      wait_idle("a5");
      check_eq("a5_done_at", last_done - t0_a, 32'd159);
      check_eq("a5_pops", pop_cnt - pops0, 32'd1);

      // Even parity, 0x03 -> parity 0
      bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
      push(8'h03);
      capture("par_e", 11, frame_a, t0_a);
      check_eq("par_e_frame", 32'(frame_a), 32'({1'b1, 1'b0, 8'h03, 1'b0}));
      wait_idle("par_e");
      check_eq("par_e_done_at", last_done - t0_a, 32'd175);

      // Odd parity, 0x03 -> parity 1
      odd_n_even = 1'b1;
      push(8'h03);
      capture("par_o", 11, frame_a, t0_a);
      check_eq("par_o_frame", 32'(frame_a), 32'({1'b1, 1'b1, 8'h03, 1'b0}));
      wait_idle("par_o");
      check_eq("par_o_done_at", last_done - t0_a, 32'd175);

      // 7-bit mode, 0xFF: 9-bit frame
      bit8 = 1'b0; parity_en = 1'b0; odd_n_even = 1'b0;
      push(8'hFF);
      capture("b7", 9, frame_a, t0_a);
      check_eq("b7_frame", 32'(frame_a), 32'({1'b1, 7'h7F, 1'b0}));
      wait_idle("b7");
      check_eq("b7_done_at", last_done - t0_a, 32'd143);

      // Back-to-back 0x55, 0x0F
      bit8 = 1'b1;
      pops0  = pop_cnt;
      dones0 = done_cnt;
      push(8'h55);
      push(8'h0F);
      capture("b2b1", 10, frame_a, t0_a);
      capture("b2b2", 10, frame_b, t0_b);
      d1 = last_done;
      check_eq("b2b_frame1", 32'(frame_a), 32'({1'b1, 8'h55, 1'b0}));
      check_eq("b2b_frame2", 32'(frame_b), 32'({1'b1, 8'h0F, 1'b0}));
      check_eq("b2b_pop_gap", last_pop - d1, 32'd1);
      check_eq("b2b_start_gap", t0_b - d1, 32'd4);
      wait_idle("b2b");
      check_eq("b2b_pops", pop_cnt - pops0, 32'd2);
      check_eq("b2b_dones", done_cnt - dones0, 32'd2);

      // Sparse baud (every 4th cycle), 0x80, config toggled mid-frame
      baud_div = 4;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      push(8'h80);
      fork
         capture("sparse", 10, frame_a, t0_a);
         begin
            repeat (300) @(negedge clock);
            bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
         end
      join
      check_eq("sparse_frame", 32'(frame_a), 32'({1'b1, 8'h80, 1'b0}));
      wait_idle("sparse");
      // Data bit 7 rises, then bit 7 + stop = 128 clocks to the last tick.
      check_eq("sparse_tail", last_done - last_rise, 32'd127);
      baud_div = 1;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      repeat (4) @(negedge clock);

      // Reset in the middle of DATA
      push(8'h00);
      capture("rst_mid", 1, frame_a, t0_a);
      repeat (40) @(negedge clock);
      check_eq("pre_rst_tx", 32'(tx), 32'd0);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_tx", 32'(tx), 32'd1);
      check_eq("mid_rst_read_n", 32'(fifo_read_n), 32'd1);
      check_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      pops0  = pop_cnt;
      falls0 = fall_cnt;
      repeat (400) @(negedge clock);
      check_eq("post_rst_falls", fall_cnt - falls0, 32'd0);
      check_eq("post_rst_pops", pop_cnt - pops0, 32'd0);
      check_eq("post_rst_tx", 32'(tx), 32'd1);
      check_eq("post_rst_busy", 32'(tx_busy), 32'd0);

      check_eq("pop_while_empty", bad_pop, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
